// File: rtl/seg7_scan.sv
// Multiplexed seven-segment driver: frame-synchronous latch/shadow update, hex decode,
// leading-zero blanking and a one-cycle blank slot after every digit change.
module seg7_scan #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int LZ_BLANK = 1
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   iData,
  input  logic [DIGITS-1:0]     iDp,
  input  logic                  iLoad,
  input  logic                  iEn,
  output logic [DIGITS-1:0]     oDigit,
  output logic [6:0]            oDisplay,
  output logic                  oDp,
  output logic                  oFrame,
  output logic                  oPending
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]    div_q, div_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] lat_data_q, lat_data_d, sh_data_q, sh_data_d;
  logic [DIGITS-1:0]   lat_dp_q, lat_dp_d, sh_dp_q, sh_dp_d;
  logic                pend_q, pend_d, frame_q, frame_d, dp_q, dp_d;
  logic [DIGITS-1:0]   digit_q, digit_d;
  logic [6:0]          disp_q, disp_d;

  logic                tick_s, wrap_s, dp_sel_s, blank_sel_s;
  logic [3:0]          nib_s;
  logic [DIGITS-1:0]   lz_mask_s;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      4'hF: hex_to_seg = 7'h71;
      default: hex_to_seg = 7'h00;
    endcase
  endfunction

  assign tick_s      = (div_q == DIV_LAST);
  assign wrap_s      = tick_s && (idx_q == IDX_LAST);
  assign nib_s       = 4'(sh_data_q >> {idx_q, 2'b00});
  assign dp_sel_s    = 1'(sh_dp_q >> idx_q);
  assign blank_sel_s = 1'(lz_mask_s >> idx_q);

  // A digit is blanked when it and every more-significant digit are zero and its dp is off.
  always_comb begin : lz_mask_p
    logic zrun;
    zrun      = 1'b1;
    lz_mask_s = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zrun         = zrun && (sh_data_q[4*i +: 4] == 4'h0);
      lz_mask_s[i] = (LZ_BLANK != 0) && (i != 0) && zrun && !sh_dp_q[i];
    end
  end

  always_comb begin
    div_d      = tick_s ? '0 : div_q + DIV_W'(1);
    idx_d      = idx_q;
    sh_data_d  = sh_data_q;
    sh_dp_d    = sh_dp_q;
    lat_data_d = lat_data_q;
    lat_dp_d   = lat_dp_q;
    pend_d     = pend_q;
    frame_d    = wrap_s;
    if (tick_s) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end else begin
      idx_d = idx_q;
    end
    // Shadow takes the old latch before a coincident load overwrites it.
    if (wrap_s && pend_q) begin
      sh_data_d = lat_data_q;
      sh_dp_d   = lat_dp_q;
      pend_d    = 1'b0;
    end else begin
      sh_data_d = sh_data_q;
      sh_dp_d   = sh_dp_q;
    end
    if (iLoad) begin
      lat_data_d = iData;
      lat_dp_d   = iDp;
      pend_d     = 1'b1;
    end else begin
      lat_data_d = lat_data_q;
      lat_dp_d   = lat_dp_q;
    end
  end

  always_comb begin
    digit_d = '1;
    disp_d  = 7'h00;
    dp_d    = 1'b0;
    if (!iEn || tick_s) begin
      digit_d = '1;
      disp_d  = 7'h00;
      dp_d    = 1'b0;
    end else begin
      digit_d = ~(DIGITS'(1) << idx_q);
      if (blank_sel_s) begin
        disp_d = 7'h00;
        dp_d   = 1'b0;
      end else begin
        disp_d = hex_to_seg(nib_s);
        dp_d   = dp_sel_s;
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      idx_q      <= '0;
      lat_data_q <= '0;
      lat_dp_q   <= '0;
      sh_data_q  <= '0;
      sh_dp_q    <= '0;
      pend_q     <= 1'b0;
      frame_q    <= 1'b0;
      digit_q    <= '1;
      disp_q     <= 7'h00;
      dp_q       <= 1'b0;
    end else begin
      div_q      <= div_d;
      idx_q      <= idx_d;
      lat_data_q <= lat_data_d;
      lat_dp_q   <= lat_dp_d;
      sh_data_q  <= sh_data_d;
      sh_dp_q    <= sh_dp_d;
      pend_q     <= pend_d;
      frame_q    <= frame_d;
      digit_q    <= digit_d;
      disp_q     <= disp_d;
      dp_q       <= dp_d;
    end
  end

  assign oDigit   = digit_q;
  assign oDisplay = disp_q;
  assign oDp      = dp_q;
  assign oFrame   = frame_q;
  assign oPending = pend_q;

endmodule
